tft_frame_scheduler: RTL and testbench
======================================

// Module: tft_frame_scheduler
// PURPOSE
//  Sequences the pixel stream into the ILI9341 SPI driver and sits between it and the per-layer renderers.
//  Owns the x/y scan counters (column-major: y inner 0..239, x outer 0..319) and resolves layer-hit priority into a registered RGB565 pixel.
//  Grants game logic a frame-boundary update window during which the TFT stream is stalled, so layer state never tears mid-frame.
// PARAMETERS
//  H_PIX       320        columns (x range 0..H_PIX-1)
//  V_PIX       240        rows (y range 0..V_PIX-1)
//  N_LAYERS    4          layer-hit inputs; index 0 = highest priority
//  LAYER_RGB   {N_LAYERS{16'h0000}}  packed RGB565 per layer, layer i at [16*i +: 16]
//  BG_RGB      16'hFFFF   colour when no layer hits
//  HIT_RGB     16'hF800   colour while override asserted
//  HOLD_MAX    65535      max cycles in HOLD before forced exit
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous, active-low reset
//  en           in   1        scan enable; sampled at frame boundaries
//  px_req       in   1        1-cycle pixel request pulse from TFT driver
//  px_vld       out  1        1-cycle pulse: px_rgb valid
//  px_rgb       out  16       RGB565 pixel to TFT driver
//  tft_stall    out  1        high: driver must not issue px_req
//  x            out  9        current x coordinate to renderers (registered)
//  y            out  8        current y coordinate to renderers (registered)
//  layer_hit    in   N_LAYERS renderer hits for current (x,y), combinational from x/y
//  override     in   1        force HIT_RGB (fatal collision)
//  upd_req      in   1        game logic requests update window (level)
//  upd_gnt      out  1        window open; layer state may change
//  upd_done     in   1        1-cycle pulse: update finished
//  frame_start  out  1        1-cycle pulse when pixel (0,0) is issued
//  frame_done   out  1        1-cycle pulse after pixel (H_PIX-1,V_PIX-1) is issued
//  frame_cnt    out  8        completed frames, wraps 255->0
//  hold_timeout out  1        sticky; set on forced HOLD exit, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, x=0, y=0, px_vld=0, px_rgb=0, tft_stall=1, upd_gnt=0, pulses=0, frame_cnt=0, hold_timeout=0.
//  States: IDLE -> SCAN when en=1 (tft_stall drops the next cycle). SCAN -> FEND on frame_done. FEND (1 cycle) -> HOLD if upd_req, else SCAN if en, else IDLE.
//  HOLD: tft_stall=1, upd_gnt=1; exit on upd_done or on HOLD_MAX cycles elapsed (sets hold_timeout). Exit goes to SCAN if en, else IDLE; upd_gnt drops the same cycle.
//  tft_stall=1 in IDLE, FEND and HOLD; 0 in SCAN. px_req while stalled is ignored: no px_vld, counters unchanged.
//  Pipeline (SCAN): px_req at cycle t samples the x/y presented since the previous advance.
//   Renderers see x/y; layer_hit is evaluated the same cycle.
//   px_rgb is registered, px_vld=1 at t+1.
//   x/y advance at t+1.
//  Colour: override ? HIT_RGB : lowest set index i of layer_hit -> LAYER_RGB[i] : BG_RGB.
//  Advance: y+1; at y=V_PIX-1, y=0 and x+1; at (H_PIX-1, V_PIX-1), wrap to (0,0), frame_done=1 and frame_cnt+1.
//  frame_start pulses with the px_vld of pixel (0,0).
//  px_req on consecutive cycles is legal: one pixel per cycle, no drops.
//  en=0 mid-frame: the frame completes; en is evaluated only in FEND.
//  upd_req takes priority over en=0 in FEND. upd_req deasserted before FEND means no HOLD.
//  upd_done outside HOLD is ignored. upd_done on the same cycle as the timeout counts as done; hold_timeout is not set.
//  Async reset mid-frame returns everything to reset values immediately; the next frame restarts at (0,0).
// STRUCTURE
//  Package tft_pkg: typedef rgb565_t (logic[15:0]), enum sched_state_e {IDLE,SCAN,FEND,HOLD}, constants TFT_W=320, TFT_H=240.
//  Sub-module scan_counter: x/y counter with adv input, wrap and last-pixel flag.
//  FSM, priority mux and hold timer stay in the top module.
// TESTING
//  Reset then en=1: after 1 cycle tft_stall=0, x=0, y=0; px_req -> px_vld next cycle, frame_start=1.
//  No layer hits -> px_rgb=16'hFFFF. layer_hit=4'b0110 -> LAYER_RGB[1]. override=1 with layer_hit=4'b0001 -> 16'hF800.
//  76800 back-to-back px_req: y wraps 239->0 with x+1; frame_done pulses once at (319,239), then x=y=0; frame_cnt=1.
//  upd_req held across the frame end: FEND then HOLD, upd_gnt=1, tft_stall=1; px_req ignored; upd_done -> SCAN.
//  HOLD_MAX=16, upd_done never sent: exit after 16 cycles; hold_timeout=1 and stays 1 through later frames.
//  en=0 at pixel 100 -> frame finishes to 76800 pixels, then IDLE. rst pulse mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/tft_frame_scheduler_pkg.sv
// Shared types and constants for the TFT frame scheduler.
//   rgb565_t       : one RGB565 pixel
//   sched_state_e  : scheduler FSM states
//   TFT_W / TFT_H  : panel size in pixels; X_W / Y_W : coordinate widths
package tft_pkg;

  localparam int unsigned TFT_W = 320;
  localparam int unsigned TFT_H = 240;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned RGB_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef logic [RGB_W-1:0] rgb565_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FEND = 2'd2,
    HOLD = 2'd3
  } sched_state_e;

endpackage

// File: rtl/tft_frame_scheduler_if.sv
// Pixel stream handshake between the scheduler and the ILI9341 SPI driver.
//   px_req    : driver -> scheduler, 1-cycle pixel request
//   px_vld    : scheduler -> driver, 1-cycle pulse, px_rgb valid
//   px_rgb    : scheduler -> driver, RGB565 pixel
//   tft_stall : scheduler -> driver, driver must not request while high
// master = scheduler side, slave = driver side.
interface tft_frame_scheduler_if;
  import tft_pkg::*;

  logic    px_req;
  logic    px_vld;
  rgb565_t px_rgb;
  logic    tft_stall;

  modport master (input px_req, output px_vld, output px_rgb, output tft_stall);
  modport slave  (output px_req, input px_vld, input px_rgb, input tft_stall);

endinterface

// File: rtl/tft_frame_scheduler_scan_counter.sv
// Column-major scan counter: y is the inner index, x the outer one.
//   clk, rst : clock, async active-low reset
//   adv      : advance one pixel this cycle
//   x, y     : registered current coordinate
//   last_c   : current coordinate is the final pixel of the frame
module scan_counter
  import tft_pkg::*;
#(
  parameter int unsigned H_PIX = TFT_W,
  parameter int unsigned V_PIX = TFT_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_c
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_end_c, y_end_c;

  assign x_end_c = (x_q == X_W'(H_PIX - 1));
  assign y_end_c = (y_q == Y_W'(V_PIX - 1));
  assign last_c  = x_end_c && y_end_c;

  // Next coordinate: y wraps into x, x wraps to start a new frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      if (y_end_c) begin
        y_d = '0;
        x_d = x_end_c ? '0 : x_q + X_W'(1);
      end else begin
        y_d = y_q + Y_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/tft_frame_scheduler.sv
// Frame scheduler between the per-layer renderers and the ILI9341 SPI driver.
// Scans x/y, resolves layer priority into a registered RGB565 pixel and opens
// an update window for game logic between frames while the TFT stream stalls.
//   clk, rst     : clock, async active-low reset
//   en           : scan enable, evaluated at frame boundaries
//   px_if        : pixel handshake (px_req in; px_vld, px_rgb, tft_stall out)
//   x, y         : coordinate presented to the renderers
//   layer_hit    : renderer hits for (x,y), index 0 highest priority
//   override     : force HIT_RGB
//   upd_req/gnt/done : update window handshake
//   frame_start, frame_done, frame_cnt, hold_timeout : frame status
module tft_frame_scheduler
  import tft_pkg::*;
#(
  parameter int unsigned               H_PIX     = TFT_W,
  parameter int unsigned               V_PIX     = TFT_H,
  parameter int unsigned               N_LAYERS  = 4,
  parameter logic [16*N_LAYERS-1:0]    LAYER_RGB = '0,
  parameter rgb565_t                   BG_RGB    = 16'hFFFF,
  parameter rgb565_t                   HIT_RGB   = 16'hF800,
  parameter int unsigned               HOLD_MAX  = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  tft_frame_scheduler_if.master px_if,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  input  logic [N_LAYERS-1:0]   layer_hit,
  input  logic                  override,
  input  logic                  upd_req,
  output logic                  upd_gnt,
  input  logic                  upd_done,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  hold_timeout
);

  localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  sched_state_e      state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_to_q, hold_to_d;
  logic              px_vld_q, px_vld_d;
  rgb565_t           px_rgb_q, px_rgb_d;
  logic              stall_q, stall_d;
  logic              upd_gnt_q, upd_gnt_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              adv_c;
  logic              last_c;
  logic              first_c;
  rgb565_t           colour_c;

  scan_counter #(
    .H_PIX (H_PIX),
    .V_PIX (V_PIX)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv_c),
    .x      (x),
    .y      (y),
    .last_c (last_c)
  );

  assign first_c = (x == '0) && (y == '0);

  // Priority mux: walk from lowest priority up so the lowest set index wins.
  always_comb begin
    colour_c = BG_RGB;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i]) colour_c = LAYER_RGB[16*i +: 16];
    end
    if (override) colour_c = HIT_RGB;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    hold_to_d     = hold_to_q;
    px_vld_d      = 1'b0;
    px_rgb_d      = px_rgb_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    adv_c         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = SCAN;
      end
      SCAN: begin
        if (px_if.px_req) begin
          adv_c         = 1'b1;
          px_vld_d      = 1'b1;
          px_rgb_d      = colour_c;
          frame_start_d = first_c;
          // Leaving SCAN on the last accept stalls the driver before it can
          // request pixel (0,0) of the next frame.
          if (last_c) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            state_d      = FEND;
          end
        end
      end
      FEND: begin
        hold_cnt_d = '0;
        if (upd_req)  state_d = HOLD;
        else if (en)  state_d = SCAN;
        else          state_d = IDLE;
      end
      HOLD: begin
        // A done arriving with the timeout is treated as a normal exit.
        if (upd_done) begin
          state_d = en ? SCAN : IDLE;
        end else if (hold_cnt_q == HOLD_W'(HOLD_MAX - 1)) begin
          hold_to_d = 1'b1;
          state_d   = en ? SCAN : IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d   = (state_d != SCAN);
    upd_gnt_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      hold_to_q     <= 1'b0;
      px_vld_q      <= 1'b0;
      px_rgb_q      <= '0;
      stall_q       <= 1'b1;
      upd_gnt_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      hold_to_q     <= hold_to_d;
      px_vld_q      <= px_vld_d;
      px_rgb_q      <= px_rgb_d;
      stall_q       <= stall_d;
      upd_gnt_q     <= upd_gnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign px_if.px_vld    = px_vld_q;
  assign px_if.px_rgb    = px_rgb_q;
  assign px_if.tft_stall = stall_q;
  assign upd_gnt         = upd_gnt_q;
  assign frame_start     = frame_start_q;
  assign frame_done      = frame_done_q;
  assign frame_cnt       = frame_cnt_q;
  assign hold_timeout    = hold_to_q;

endmodule

// File: tb/tb_tft_frame_scheduler.sv
// Bench for tft_frame_scheduler on a reduced 8x6 panel with HOLD_MAX=16.
// The reference treats the scan as a pixel index n: x = n / V, y = n % V.
module tb_tft_frame_scheduler;
  import tft_pkg::*;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 6;
  localparam int unsigned NL   = 4;
  localparam int unsigned HM   = 16;
  localparam int unsigned NPIX = H * V;
  localparam logic [63:0] LRGB = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [15:0] BG   = 16'hFFFF;
  localparam logic [15:0] HIT  = 16'hF800;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [NL-1:0] layer_hit;
  logic          override;
  logic          upd_req;
  logic          upd_gnt;
  logic          upd_done;
  logic          frame_start;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          hold_timeout;

  tft_frame_scheduler_if px_if ();

  tft_frame_scheduler #(
    .H_PIX     (H),
    .V_PIX     (V),
    .N_LAYERS  (NL),
    .LAYER_RGB (LRGB),
    .BG_RGB    (BG),
    .HIT_RGB   (HIT),
    .HOLD_MAX  (HM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .px_if        (px_if),
    .x            (x),
    .y            (y),
    .layer_hit    (layer_hit),
    .override     (override),
    .upd_req      (upd_req),
    .upd_gnt      (upd_gnt),
    .upd_done     (upd_done),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pix_n  = 0;
  int frames = 0;
  int gnt_cycles;
  logic [15:0] layer_col [NL] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_colour(input logic ovr, input logic [NL-1:0] hit);
    if (ovr) return HIT;
    for (int i = 0; i < NL; i++) if (hit[i]) return layer_col[i];
    return BG;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic ovr, input logic [NL-1:0] hit);
    logic [15:0] exp_rgb;
    int n;
    n = pix_n;
    chk("x_pre", 32'(x), 32'(n / V));
    chk("y_pre", 32'(y), 32'(n % V));
    exp_rgb = ref_colour(ovr, hit);
    px_if.px_req = 1'b1;
    override     = ovr;
    layer_hit    = hit;
    tick();
    px_if.px_req = 1'b0;
    override     = 1'b0;
    layer_hit    = '0;
    chk("px_vld", 32'(px_if.px_vld), 32'd1);
    chk("px_rgb", 32'(px_if.px_rgb), 32'(exp_rgb));
    chk("frame_start", 32'(frame_start), 32'(n == 0));
    chk("frame_done", 32'(frame_done), 32'(n == NPIX - 1));
    pix_n = (n + 1) % NPIX;
    if (pix_n == 0) frames++;
    chk("frame_cnt", 32'(frame_cnt), 32'(frames % 256));
    chk("x_post", 32'(x), 32'(pix_n / V));
    chk("y_post", 32'(y), 32'(pix_n % V));
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      tick();
      chk("vld_idle", 32'(px_if.px_vld), 32'd0);
    end
  endtask

  task automatic run_pixels(input int count);
    for (int i = 0; i < count; i++) begin
      idle_cycles(int'($urandom_range(0, 2)));
      send_px(($urandom_range(0, 9) == 0), NL'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; px_if.px_req = 1'b0; layer_hit = '0;
    override = 1'b0; upd_req = 1'b0; upd_done = 1'b0;
    tick(); tick();
    chk("rst_stall", 32'(px_if.tft_stall), 32'd1);
    chk("rst_vld", 32'(px_if.px_vld), 32'd0);
    chk("rst_rgb", 32'(px_if.px_rgb), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_gnt", 32'(upd_gnt), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_to", 32'(hold_timeout), 32'd0);
    chk("rst_pulses", 32'({frame_start, frame_done}), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_stall", 32'(px_if.tft_stall), 32'd1);

    // Requests in IDLE are ignored
    px_if.px_req = 1'b1;
    tick();
    px_if.px_req = 1'b0;
    chk("idle_req_vld", 32'(px_if.px_vld), 32'd0);
    chk("idle_req_y", 32'(y), 32'd0);

    // Frame 1: directed colours then randomized pixels
    en = 1'b1;
    tick();
    chk("scan_stall", 32'(px_if.tft_stall), 32'd0);
    send_px(1'b0, 4'b0000);
    send_px(1'b0, 4'b0110);
    send_px(1'b1, 4'b0001);
    run_pixels(NPIX - 3);
    chk("fend_stall", 32'(px_if.tft_stall), 32'd1);
    tick();
    chk("f1_rescan_stall", 32'(px_if.tft_stall), 32'd0);
    chk("f1_rescan_gnt", 32'(upd_gnt), 32'd0);

    // Frame 2: stray upd_done, upd_req withdrawn before frame end
    upd_done = 1'b1;
    send_px(1'b0, 4'b1000);
    upd_done = 1'b0;
    upd_req = 1'b1;
    run_pixels(10);
    upd_req = 1'b0;
    run_pixels(NPIX - 11);
    tick();
    chk("f2_nohold_gnt", 32'(upd_gnt), 32'd0);
    chk("f2_nohold_stall", 32'(px_if.tft_stall), 32'd0);

    // Frame 3: update window closed by upd_done
    upd_req = 1'b1;
    run_pixels(NPIX);
    chk("f3_fend_stall", 32'(px_if.tft_stall), 32'd1);
    tick();
    chk("hold_gnt", 32'(upd_gnt), 32'd1);
    chk("hold_stall", 32'(px_if.tft_stall), 32'd1);
    px_if.px_req = 1'b1;
    repeat (3) begin
      tick();
      chk("hold_req_vld", 32'(px_if.px_vld), 32'd0);
      chk("hold_req_x", 32'(x), 32'd0);
      chk("hold_req_y", 32'(y), 32'd0);
    end
    px_if.px_req = 1'b0;
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    upd_req = 1'b0;
    chk("done_gnt", 32'(upd_gnt), 32'd0);
    chk("done_stall", 32'(px_if.tft_stall), 32'd0);
    chk("done_to", 32'(hold_timeout), 32'd0);

    // Frame 4: window never completed, forced exit after HM cycles
    upd_req = 1'b1;
    run_pixels(NPIX);
    tick();
    gnt_cycles = 0;
    for (int k = 0; k < 4 * HM && upd_gnt === 1'b1; k++) begin
      gnt_cycles++;
      tick();
    end
    upd_req = 1'b0;
    chk("hold_len", 32'(gnt_cycles), 32'(HM));
    chk("timeout_set", 32'(hold_timeout), 32'd1);
    chk("timeout_stall", 32'(px_if.tft_stall), 32'd0);

    // Frame 5: en dropped mid-frame, frame still completes, then IDLE
    for (int i = 0; i < NPIX; i++) begin
      if (i == 10) en = 1'b0;
      idle_cycles(int'($urandom_range(0, 1)));
      send_px(($urandom_range(0, 7) == 0), NL'($urandom));
    end
    chk("f5_timeout_sticky", 32'(hold_timeout), 32'd1);
    tick();
    chk("f5_idle_stall", 32'(px_if.tft_stall), 32'd1);
    px_if.px_req = 1'b1;
    idle_cycles(3);
    px_if.px_req = 1'b0;
    chk("f5_idle_stall2", 32'(px_if.tft_stall), 32'd1);

    // Async reset mid-frame
    en = 1'b1;
    tick();
    run_pixels(7);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", 32'(px_if.px_vld), 32'd0);
    chk("arst_rgb", 32'(px_if.px_rgb), 32'd0);
    chk("arst_stall", 32'(px_if.tft_stall), 32'd1);
    chk("arst_xy", 32'({x, y}), 32'd0);
    chk("arst_cnt", 32'(frame_cnt), 32'd0);
    chk("arst_to", 32'(hold_timeout), 32'd0);
    chk("arst_gnt", 32'(upd_gnt), 32'd0);
    tick();
    rst = 1'b1;
    pix_n = 0;
    frames = 0;
    tick();
    chk("post_rst_stall", 32'(px_if.tft_stall), 32'd0);
    run_pixels(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
